// File: rtl/jtag_ahbl_master.sv
// jtag_ahbl_master
//   AHB-Lite single-transfer master driven by JTAG Update-DR commands.
//   Runs entirely in the TCK domain. ADDRESS loads the word-aligned address
//   register. WRITE and READ each run one NONSEQ transfer: an address phase
//   followed by a data phase. Read data and sticky status are returned for
//   the next Capture-DR.
//
//   Optional feature (macro JTAG_AHBL_AUTOINC_EN): after each successfully
//   completed transfer, the address register advances by 4, wrapping modulo
//   2^ADDR_WIDTH.
//
// Ports
//   TCK, RST             clock; synchronous active-high reset
//   CMD_VALID/OP/DATA    command strobe, opcode (01 addr, 10 write, 11 read,
//                        00 nop) and payload
//   CMD_READY            idle, command can be accepted
//   RD_DATA, RD_VALID    last captured HRDATA, one-cycle update pulse
//   STATUS, STATUS_CLR   {overrun, timeout, err, busy}; clear of sticky bits
//   H*                   AHB-Lite master interface
module jtag_ahbl_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  TCK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  input  logic [1:0]            CMD_OP,
  input  logic [DATA_WIDTH-1:0] CMD_DATA,
  output logic                  CMD_READY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic [3:0]            STATUS,
  input  logic                  STATUS_CLR,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {IDLE, ADDR_PH, DATA_PH} state_t;

  localparam logic [1:0] OP_ADDR  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic                    write_q, rd_valid_q;
  logic                    ovr_q, tmo_q, err_q;
  logic [31:0]             wait_cnt;
  logic                    accept, bus_wait, tmo_hit, xfer_done;
  logic [ADDR_WIDTH-1:0]   cmd_addr;

  assign cmd_addr = ADDR_WIDTH'(CMD_DATA) & ~ADDR_WIDTH'(3);

  always_comb begin
    state_n   = state;
    accept    = CMD_VALID && (state == IDLE);
    bus_wait  = (state != IDLE) && !HREADY;
    // The phase aborts on the wait cycle that brings the count up to the limit.
    tmo_hit   = bus_wait && (TIMEOUT_CYCLES != 0) && ((wait_cnt + 32'd1) == TIMEOUT_CYCLES);
    xfer_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (CMD_OP == OP_WRITE || CMD_OP == OP_READ)) state_n = ADDR_PH;
      end
      ADDR_PH: begin
        if (HREADY)       state_n = DATA_PH;
        else if (tmo_hit) state_n = IDLE;
      end
      DATA_PH: begin
        if (HREADY) begin
          state_n   = IDLE;
          xfer_done = 1'b1;
        end else if (tmo_hit) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (RST) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state <= state_n;

      if (state_n != state) wait_cnt <= '0;
      else if (bus_wait)    wait_cnt <= wait_cnt + 32'd1;

      if (accept) begin
        case (CMD_OP)
          OP_ADDR:  addr_q <= cmd_addr;
          OP_WRITE: begin
            wdata_q <= CMD_DATA;
            write_q <= 1'b1;
          end
          OP_READ:  write_q <= 1'b0;
          default:  ;
        endcase
      end
`ifdef JTAG_AHBL_AUTOINC_EN
      else if (xfer_done && !HRESP) begin
        addr_q <= addr_q + ADDR_WIDTH'(4);
      end
`endif

      rd_valid_q <= xfer_done && !write_q;
      if (xfer_done && !write_q) rdata_q <= HRDATA;

      // Set events take priority over the clear.
      ovr_q <= (CMD_VALID && (state != IDLE)) || (ovr_q && !STATUS_CLR);
      tmo_q <= tmo_hit || (tmo_q && !STATUS_CLR);
      err_q <= (xfer_done && HRESP) || (err_q && !STATUS_CLR);
    end
  end

  assign CMD_READY = (state == IDLE);
  assign RD_DATA   = rdata_q;
  assign RD_VALID  = rd_valid_q;
  assign STATUS    = {ovr_q, tmo_q, err_q, state != IDLE};
  assign HADDR     = addr_q;
  assign HTRANS    = (state == ADDR_PH) ? 2'b10 : 2'b00;
  assign HWRITE    = write_q;
  assign HWDATA    = wdata_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;

endmodule

// File: doc/jtag_ahbl_master.md
Name: jtag_ahbl_master

Overview:
AHB-Lite single-transfer master sitting directly downstream of the JTAG TAP/instruction decoder. It consumes the ADDRESS, WRITE and READ commands produced at Update-DR of the corresponding JTAG data registers and runs the AHB-Lite transfers. It returns read data and status to the TAP for capture at the next Capture-DR. Runs entirely in the TCK domain; the bus side is clocked by TCK.

Parameters:
ADDR_WIDTH, 32, HADDR/address register width
DATA_WIDTH, 32, HWDATA/HRDATA/command payload width
TIMEOUT_CYCLES, 255, max consecutive HREADY-low cycles per phase before abort; 0 disables timeout

Ports:
TCK  in  1  clock, all logic rising-edge
RST  in  1  synchronous reset, active-high
CMD_VALID  in  1  one-cycle command strobe from TAP (Update-DR)
CMD_OP  in  2  2'b01 ADDRESS, 2'b10 WRITE, 2'b11 READ, 2'b00 NOP
CMD_DATA  in  DATA_WIDTH  address (ADDRESS) or write data (WRITE); ignored for READ
CMD_READY  out  1  high when idle and able to accept a command
RD_DATA  out  DATA_WIDTH  last captured HRDATA
RD_VALID  out  1  one-cycle pulse when RD_DATA updated
STATUS  out  4  {overrun, timeout, err, busy}
STATUS_CLR  in  1  clears sticky overrun/timeout/err
HADDR  out  ADDR_WIDTH  bus address
HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
HWRITE  out  1  transfer direction
HSIZE  out  3  constant 3'b010 (word)
HBURST  out  3  constant 3'b000 (SINGLE)
HPROT  out  4  constant 4'b0011
HWDATA  out  DATA_WIDTH  write data, valid in data phase
HREADY  in  1  bus ready
HRDATA  in  DATA_WIDTH  bus read data
HRESP  in  1  bus error response

Behaviour:
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, RD_DATA=0, RD_VALID=0, STATUS=0, CMD_READY=1, address register=0, state IDLE. Reset mid-transfer: all of the above on the next edge; no transfer completion reported.
- States: IDLE, ADDR_PH, DATA_PH.
- IDLE: CMD_READY=1, HTRANS=00. CMD_VALID with ADDRESS: addr reg <= CMD_DATA with [1:0] forced 00, stays IDLE, no bus activity. WRITE: wdata reg <= CMD_DATA, -> ADDR_PH. READ -> ADDR_PH. NOP: no effect.
- ADDR_PH: HTRANS=10, HADDR=addr reg, HWRITE=1 for WRITE / 0 for READ, busy=1, CMD_READY=0. Held until HREADY=1 sampled, then -> DATA_PH.
- DATA_PH: HTRANS=00; HWDATA=wdata reg (WRITE). On HREADY=1: READ captures HRDATA into RD_DATA and pulses RD_VALID the following cycle; HRESP=1 sets err (read data still captured); -> IDLE. So a zero-wait transfer takes 2 cycles from acceptance; CMD_READY is high again on the 3rd edge.
- HADDR/HWRITE/HWDATA hold stable while HREADY=0.
- Timeout: per-phase counter reset on phase entry; when TIMEOUT_CYCLES consecutive HREADY-low cycles elapse, set timeout, drive HTRANS=00, -> IDLE, no RD_VALID. TIMEOUT_CYCLES=0: wait forever.
- CMD_VALID while CMD_READY=0: command dropped, overrun set.
- STATUS_CLR clears overrun/timeout/err next edge; a set event in the same cycle wins (flag stays 1). busy = state!=IDLE, not sticky.

Optional Feature:
JTAG_AHBL_AUTOINC_EN: when defined, a completed WRITE or READ (HREADY=1 in DATA_PH, HRESP=0) increments the address register by 4, wrapping modulo 2^ADDR_WIDTH, so repeated DR shifts stream consecutive words; no increment on error or timeout. When undefined, the address register changes only on an ADDRESS command.

Test Plan:
- Reset then ADDRESS 32'h0000_1003 -> addr reg 32'h0000_1000, HTRANS stays 00, CMD_READY stays 1.
- WRITE 32'hDEAD_BEEF, HREADY=1 -> one cycle HTRANS=10/HWRITE=1/HADDR=32'h1000, next cycle HWDATA=32'hDEAD_BEEF, CMD_READY back after 2 cycles.
- READ with HRDATA=32'hF00F and 3 HREADY-low cycles in data phase -> HADDR held, RD_DATA=32'hF00F, single RD_VALID pulse, STATUS=0.
- READ with HRESP=1 -> STATUS[1]=1; STATUS_CLR -> 0; WRITE issued while busy -> STATUS[3]=1, command dropped.
- HREADY held low, TIMEOUT_CYCLES=4 -> abort after 4 cycles, STATUS[2]=1, HTRANS=00; RST asserted mid ADDR_PH -> all reset values next edge.
- With JTAG_AHBL_AUTOINC_EN: ADDRESS 32'hFFFF_FFFC then two READs -> HADDR FFFF_FFFC then 0000_0000; without macro both use FFFF_FFFC.
